// File: rtl/sshooter_snd_pkg.sv
// Shared types, Q15 constants and helpers for the sound-chain filter blocks.
package sshooter_snd_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [17:0] coef_t;

  localparam int Q15_SHIFT = 15;
  localparam int Q15_HALF  = 16384;
  localparam int SMP_MAX   = 32767;
  localparam int SMP_MIN   = -32768;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M_B1,
    ST_M_B2,
    ST_M_A2,
    ST_FIN
  } iir_st_t;

  function automatic sample_t sat16(input logic signed [35:0] v);
    if (v > 36'(SMP_MAX)) begin
      return sample_t'(SMP_MAX);
    end else if (v < 36'(SMP_MIN)) begin
      return sample_t'(SMP_MIN);
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/snd_sample_div.sv
// Sample-rate divider: one-cycle tick every DIV clocks, shared by the sound filters.
module snd_sample_div #(
  parameter int DIV = 128
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sshooter_fm_hpf.sv
// First-order Q15 DC-blocking high-pass on the YM2203 FM path.
// One 16x18 multiplier is time-shared across the three filter terms.
module sshooter_fm_hpf
  import sshooter_snd_pkg::*;
#(
  parameter int    DIV = 128,
  parameter coef_t B1  = 18'sd32760,
  parameter coef_t B2  = -18'sd32760,
  parameter coef_t A2  = -18'sd32752
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t in,
  output sample_t out,
  output logic    out_stb
);

  // state | meaning
  // IDLE  | waiting for tick; x_cur latched on tick
  // M_B1  | acc = B1*x_cur
  // M_B2  | acc += B2*x_prev
  // M_A2  | acc -= A2*y_prev; rounded/saturated result and history registered
  // FIN   | new out presented with out_stb high

  iir_st_t              r_state;
  sample_t              r_x_cur;
  sample_t              r_x_prev;
  sample_t              r_y_prev;
  sample_t              r_out;
  logic                 r_out_stb;
  logic signed [35:0]   r_acc;

  logic                 w_tick;
  sample_t              w_mul_a;
  coef_t                w_mul_b;
  logic signed [33:0]   w_prod;
  logic signed [35:0]   w_prod_ext;
  logic signed [35:0]   w_acc_fin;
  logic signed [35:0]   w_rnd;
  sample_t              w_sat;

  snd_sample_div #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      ST_M_B1: begin
        w_mul_a = r_x_cur;
        w_mul_b = B1;
      end
      ST_M_B2: begin
        w_mul_a = r_x_prev;
        w_mul_b = B2;
      end
      ST_M_A2: begin
        w_mul_a = r_y_prev;
        w_mul_b = A2;
      end
      default: begin
        w_mul_a = '0;
        w_mul_b = '0;
      end
    endcase
  end

  assign w_prod     = 34'(w_mul_a) * 34'(w_mul_b);
  assign w_prod_ext = 36'(w_prod);
  assign w_acc_fin  = r_acc - w_prod_ext;
  // Round half up, then arithmetic shift floors toward minus infinity.
  assign w_rnd      = (w_acc_fin + 36'(Q15_HALF)) >>> Q15_SHIFT;
  assign w_sat      = sat16(w_rnd);

  // Result is registered on the M_A2 edge so the strobe lands in the FIN cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_x_cur   <= '0;
      r_x_prev  <= '0;
      r_y_prev  <= '0;
      r_acc     <= '0;
      r_out     <= '0;
      r_out_stb <= 1'b0;
    end else begin
      r_out_stb <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_x_cur <= in;
            r_state <= ST_M_B1;
          end
        end
        ST_M_B1: begin
          r_acc   <= w_prod_ext;
          r_state <= ST_M_B2;
        end
        ST_M_B2: begin
          r_acc   <= r_acc + w_prod_ext;
          r_state <= ST_M_A2;
        end
        ST_M_A2: begin
          r_acc     <= w_acc_fin;
          r_out     <= w_sat;
          r_y_prev  <= w_sat;
          r_x_prev  <= r_x_cur;
          r_out_stb <= 1'b1;
          r_state   <= ST_FIN;
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out     = r_out;
  assign out_stb = r_out_stb;

endmodule

// File: tb/tb_sshooter_fm_hpf.sv
// Self-checking bench: default-DIV instance for directed phases, DIV=8 instance under random drive.
module tb_sshooter_fm_hpf;
  import sshooter_snd_pkg::*;

  logic    clk;
  logic    rst_a, rst_b;
  sample_t in_a, in_b;
  sample_t out_a, out_b;
  logic    stb_a, stb_b;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 0;

  sshooter_fm_hpf dut_a (
    .clk     (clk),
    .reset   (rst_a),
    .in      (in_a),
    .out     (out_a),
    .out_stb (stb_a)
  );

  sshooter_fm_hpf #(.DIV(8)) dut_b (
    .clk     (clk),
    .reset   (rst_b),
    .in      (in_b),
    .out     (out_b),
    .out_stb (stb_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic signed [63:0] got,
                              input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Filter equation in plain integer arithmetic with explicit floor and clamp.
  function automatic int hpf_step(input int x, input int xprev, input int yprev);
    longint acc, num, q;
    acc = longint'(x) * 32760 - longint'(xprev) * 32760 + longint'(yprev) * 32752;
    num = acc + 16384;
    q   = num / 32768;
    if ((num % 32768 != 0) && (num < 0)) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Model: cycles since release, history, and one scheduled output per instance.
  int k[2], xp[2], yp[2], pc[2], pval[2], eo[2];
  bit pv[2], es[2], mv[2];
  int divs[2] = '{128, 8};

  int cap_val[$];
  int cap_cyc[$];
  int last_b = -1;

  task automatic model_edge(input int d, input bit rst_n, input int x);
    int y;
    if (!rst_n) begin
      k[d] = 0; xp[d] = 0; yp[d] = 0; pv[d] = 0; eo[d] = 0; es[d] = 0; mv[d] = 1;
    end else if (mv[d]) begin
      es[d] = 0;
      if (pv[d]) begin
        pc[d]--;
        if (pc[d] == 0) begin
          eo[d] = pval[d]; es[d] = 1; pv[d] = 0;
        end
      end
      if (k[d] % divs[d] == divs[d] - 1) begin
        y = hpf_step(x, xp[d], yp[d]);
        xp[d] = x; yp[d] = y;
        pv[d] = 1; pc[d] = 3; pval[d] = y;
      end
      k[d]++;
    end
  endtask

  always @(negedge clk) begin
    if (mv[0]) begin
      chk("a_out", out_a, eo[0]);
      chk("a_stb", stb_a, es[0]);
      chk("a_tick_busy", (dut_a.w_tick && dut_a.r_state != ST_IDLE), 0);
      if (stb_a === 1'b1) begin
        cap_val.push_back(int'(out_a));
        cap_cyc.push_back(k[0]);
      end
    end
    if (mv[1]) begin
      chk("b_out", out_b, eo[1]);
      chk("b_stb", stb_b, es[1]);
      chk("b_tick_busy", (dut_b.w_tick && dut_b.r_state != ST_IDLE), 0);
      if (stb_b === 1'b1) begin
        if (last_b >= 0) chk("b_stb_spacing", k[1] - last_b, 8);
        last_b = k[1];
      end
    end
    if (!rst_b) last_b = -1;
    model_edge(0, rst_a, int'(in_a));
    model_edge(1, rst_b, int'(in_b));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_stb_a(input int budget, input string name);
    int n0, t;
    n0 = cap_val.size();
    t  = 0;
    while (cap_val.size() == n0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(name, (cap_val.size() != n0), 1);
  endtask

  // Random drive for the DIV=8 instance: input changes every cycle, occasional resets.
  initial begin
    rst_b = 1'b0;
    in_b  = '0;
    cyc(5);
    rst_b = 1'b1;
    while (!done) begin
      cyc(1);
      in_b = sample_t'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_b = 1'b0;
        cyc($urandom_range(1, 3));
        rst_b = 1'b1;
      end
    end
  end

  initial begin
    int s0, bad, nz;
    rst_a = 1'b0;
    in_a  = 16'sd1234;

    // Reset values with a nonzero input present.
    cyc(3);
    chk("rst_out", out_a, 0);
    chk("rst_stb", stb_a, 0);
    cyc(2);

    // DC step: decays monotonically; rounding leaves a small positive dead band.
    s0 = cap_val.size();
    rst_a = 1'b1;
    in_a  = 16'sd10000;
    for (int i = 0; i < 40; i++) wait_stb_a(300, "dc_stb_seen");
    chk("rst_first_stb_cyc", cap_cyc[s0], 131);
    chk("dc_y0", cap_val[s0], 9998);
    chk("dc_y1", cap_val[s0+1], 9993);
    bad = 0;
    for (int i = s0 + 1; i < cap_val.size(); i++)
      if (cap_val[i] > cap_val[i-1] || cap_val[i] <= 0) bad++;
    chk("dc_monotonic_bad", bad, 0);

    // Saturation: full negative step then full positive.
    rst_a = 1'b0;
    in_a  = -16'sd32768;
    cyc(3);
    s0 = cap_val.size();
    rst_a = 1'b1;
    wait_stb_a(300, "sat_stb0_seen");
    in_a = 16'sd32767;
    wait_stb_a(300, "sat_stb1_seen");
    chk("sat_y0", cap_val[s0], -32760);
    chk("sat_y1", cap_val[s0+1], 32767);

    // Reset landing on the M_A2 cycle of a nonzero sample.
    rst_a = 1'b0;
    in_a  = 16'sd5000;
    cyc(3);
    rst_a = 1'b1;
    cyc(130);
    s0 = cap_val.size();
    rst_a = 1'b0;
    in_a  = 16'sd10000;
    cyc(2);
    rst_a = 1'b1;
    chk("midrst_no_stb", cap_val.size() - s0, 0);
    chk("midrst_out", out_a, 0);
    wait_stb_a(300, "midrst_stb_seen");
    chk("midrst_y0", cap_val[s0], 9998);
    chk("midrst_cyc", cap_cyc[s0], 131);

    // Zero input: no drift over 100 samples.
    rst_a = 1'b0;
    in_a  = '0;
    cyc(3);
    s0 = cap_val.size();
    rst_a = 1'b1;
    for (int i = 0; i < 100; i++) wait_stb_a(300, "zero_stb_seen");
    nz = 0;
    for (int i = s0; i < cap_val.size(); i++) if (cap_val[i] != 0) nz++;
    chk("zero_nonzero_count", nz, 0);
    chk("zero_count", cap_val.size() - s0, 100);

    // Random input, changed at arbitrary cycles, including extremes.
    for (int i = 0; i < 40 * 128; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0:       in_a = 16'sh7fff;
          1:       in_a = 16'sh8000;
          default: in_a = sample_t'($urandom);
        endcase
      end
      cyc(1);
    end

    done = 1;
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
